// File: rtl/alu_ctl_pkg.sv
// Shared definitions for the 8085 ALU sequencer:
// op codes, FSM states and the fixed flag-bit masks.
package alu_ctl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_ANA = 4'd4;
  localparam logic [3:0] OP_XRA = 4'd5;
  localparam logic [3:0] OP_ORA = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_INR = 4'd8;
  localparam logic [3:0] OP_DCR = 4'd9;
  localparam logic [3:0] OP_DAA = 4'd10;
  localparam logic [3:0] OP_STC = 4'd11;
  localparam logic [3:0] OP_CMC = 4'd12;
  localparam logic [3:0] OP_CMA = 4'd13;
  localparam logic [3:0] OP_LDA = 4'd14;
  localparam logic [3:0] OP_LDF = 4'd15;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DAA2 = 2'd2
  } state_e;

  localparam logic [7:0] F_SET = 8'h02;
  localparam logic [7:0] F_CLR = 8'h28;
  localparam logic [7:0] F_RST = 8'h02;

  function automatic logic [7:0] fix_flags(
    input logic [7:0] f
  );
    return (f | F_SET) & ~F_CLR;
  endfunction

endpackage

// File: rtl/alu_ctl_daa_fix.sv
// DAA correction term for one nibble: 0x06 for the
// low pass, 0x60 for the high pass, zero when not needed.
module alu_ctl_daa_fix (
  input  logic [3:0] nib,
  input  logic       adj,
  input  logic       hi,
  output logic [7:0] corr,
  output logic       need
);

  always_comb begin
    need = (nib > 4'd9) | adj;
    corr = 8'h00;
    if (need) corr = hi ? 8'h60 : 8'h06;
  end

endmodule

// File: rtl/alu_ctl.sv
// Sequencer around the external 8085 ALU: registers
// A/F, drives ALU inputs, and runs multi-pass ops.
module alu_ctl
  import alu_ctl_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int FLAG_S   = 7,
  parameter int FLAG_Z   = 6,
  parameter int FLAG_A   = 4,
  parameter int FLAG_P   = 2,
  parameter int FLAG_C   = 0
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iReq,
  output logic                oReady,
  input  logic [3:0]          iOp,
  input  logic [DATASIZE-1:0] iB,
  output logic                oDone,
  output logic [DATASIZE-1:0] oAcc,
  output logic [DATASIZE-1:0] oFlag,
  output logic [2:0]          oS,
  output logic [DATASIZE-1:0] oA,
  output logic [DATASIZE-1:0] oB,
  output logic [DATASIZE-1:0] oF,
  input  logic [DATASIZE-1:0] iY,
  input  logic [DATASIZE-1:0] iFY
);

  state_e state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] opnd_q, opnd_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] flag_q, flag_d;
  logic       done_q, done_d;
  logic [2:0] s_q, s_d;
  logic [7:0] b_q, b_d;
  logic [7:0] r1_q, r1_d;
  logic       ac1_q, ac1_d;
  logic       c1_q, c1_d;

  logic [7:0] f_tmp;
  logic [7:0] lo_corr, hi_corr;
  logic       lo_need, hi_need;

  // Pass 1 looks at A/F before the op starts.
  alu_ctl_daa_fix u_daa_lo (
    .nib  (acc_q[3:0]),
    .adj  (flag_q[FLAG_A]),
    .hi   (1'b0),
    .corr (lo_corr),
    .need (lo_need)
  );

  // Pass 2 looks at the live pass-1 ALU result.
  alu_ctl_daa_fix u_daa_hi (
    .nib  (iY[7:4]),
    .adj  (flag_q[FLAG_C] | iFY[FLAG_C]),
    .hi   (1'b1),
    .corr (hi_corr),
    .need (hi_need)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    s_d     = s_q;
    b_d     = b_q;
    r1_d    = r1_q;
    ac1_d   = ac1_q;
    c1_d    = c1_q;
    f_tmp   = flag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iReq) begin
          state_d = ST_EXEC;
          op_d    = iOp;
          opnd_d  = iB;
          if (!iOp[3]) begin
            s_d = iOp[2:0];
            b_d = iB;
          end else begin
            case (iOp)
              OP_INR: begin
                s_d = SEL_ADD;
                b_d = 8'h01;
              end
              OP_DCR: begin
                s_d = SEL_SUB;
                b_d = 8'h01;
              end
              OP_DAA: begin
                s_d = SEL_ADD;
                b_d = lo_need ? lo_corr : 8'h00;
              end
              default: ;
            endcase
          end
        end
      end
      ST_EXEC: begin
        if (op_q == OP_DAA) begin
          state_d = ST_DAA2;
          r1_d    = iY;
          ac1_d   = iFY[FLAG_A];
          c1_d    = iFY[FLAG_C];
          s_d     = SEL_ADD;
          b_d     = hi_need ? hi_corr : 8'h00;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          case (op_q)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB,
            OP_ANA, OP_XRA, OP_ORA: begin
              acc_d  = iY;
              flag_d = fix_flags(iFY);
            end
            OP_CMP: flag_d = fix_flags(iFY);
            OP_INR, OP_DCR: begin
              acc_d         = iY;
              f_tmp         = iFY;
              f_tmp[FLAG_C] = flag_q[FLAG_C];
              flag_d        = fix_flags(f_tmp);
            end
            OP_STC: begin
              f_tmp[FLAG_C] = 1'b1;
              flag_d        = fix_flags(f_tmp);
            end
            OP_CMC: begin
              f_tmp[FLAG_C] = ~flag_q[FLAG_C];
              flag_d        = fix_flags(f_tmp);
            end
            OP_CMA: acc_d  = ~acc_q;
            OP_LDA: acc_d  = opnd_q;
            OP_LDF: flag_d = fix_flags(opnd_q);
            default: ;
          endcase
        end
      end
      ST_DAA2: begin
        state_d       = ST_IDLE;
        done_d        = 1'b1;
        acc_d         = iY;
        f_tmp         = 8'h00;
        f_tmp[FLAG_S] = iFY[FLAG_S];
        f_tmp[FLAG_Z] = iFY[FLAG_Z];
        f_tmp[FLAG_P] = iFY[FLAG_P];
        f_tmp[FLAG_A] = ac1_q;
        f_tmp[FLAG_C] = flag_q[FLAG_C] | c1_q
                      | iFY[FLAG_C];
        flag_d        = fix_flags(f_tmp);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      opnd_q  <= 8'h00;
      acc_q   <= 8'h00;
      flag_q  <= F_RST;
      done_q  <= 1'b0;
      s_q     <= 3'd0;
      b_q     <= 8'h00;
      r1_q    <= 8'h00;
      ac1_q   <= 1'b0;
      c1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      s_q     <= s_d;
      b_q     <= b_d;
      r1_q    <= r1_d;
      ac1_q   <= ac1_d;
      c1_q    <= c1_d;
    end
  end

  assign oReady = (state_q == ST_IDLE);
  assign oDone  = done_q;
  assign oAcc   = acc_q;
  assign oFlag  = flag_q;
  assign oS     = s_q;
  assign oB     = b_q;
  assign oA     = (state_q == ST_DAA2) ? r1_q : acc_q;
  assign oF     = flag_q;

endmodule
